// File: rtl/matrix_pkg.sv
// ----------------------------------------------------------------------------
// matrix_pkg
//   Shared definitions for the two-player matrix paint engine:
//     - switch bit indices within each player's switch bus
//     - cursor coordinate type and cursor struct {x, y}
//     - wrap_step(): one-axis cursor step with wrap-around and
//       cancellation of opposing requests
// ----------------------------------------------------------------------------
package matrix_pkg;

    localparam int unsigned SW_UP     = 0;
    localparam int unsigned SW_DOWN   = 1;
    localparam int unsigned SW_LEFT   = 2;
    localparam int unsigned SW_RIGHT  = 3;
    localparam int unsigned SW_TOGGLE = 4;
    localparam int unsigned SW_CLEAR  = 5;
    // Number of low switch bits that carry a function; higher bits are ignored.
    localparam int unsigned SW_USED   = 6;

    // Coordinates are sized for the largest supported matrix dimension so the
    // struct stays a package type while WIDTH/HEIGHT remain top parameters.
    localparam int unsigned MAX_DIM = 256;
    localparam int unsigned COORD_W = $clog2(MAX_DIM);

    typedef logic [COORD_W-1:0] coord_t;

    typedef struct packed {
        coord_t x;
        coord_t y;
    } cursor_t;

    // Step one coordinate by +1 (inc) or -1 (dec) modulo dim. Both or neither
    // request leaves the coordinate unchanged.
    function automatic coord_t wrap_step(coord_t c, logic inc, logic dec, int unsigned dim);
        coord_t last;
        last = coord_t'(dim - 1);
        if (inc && !dec) begin
            return (c == last) ? '0 : c + coord_t'(1);
        end else if (dec && !inc) begin
            return (c == '0) ? last : c - coord_t'(1);
        end
        return c;
    endfunction

endpackage

// File: rtl/switch_edge_sync.sv
// ----------------------------------------------------------------------------
// switch_edge_sync
//   N-bit two-flop synchroniser followed by a registered rising-edge detector.
//   A switch edge captured by the first flop at clk edge n produces a one-cycle
//   pulse on rise_o that is consumed at clk edge n+3.
// Ports
//   clk     in   1  system clock
//   rst_n   in   1  asynchronous reset, active low (all flops cleared)
//   sw_i    in   N  raw switch inputs, asynchronous to clk
//   rise_o  out  N  one-cycle pulse per rising edge, registered
// ----------------------------------------------------------------------------
module switch_edge_sync #(
    parameter int unsigned N = 6
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] sw_i,
    output logic [N-1:0] rise_o
);

    logic [N-1:0] meta_q;
    logic [N-1:0] sync_q;
    logic [N-1:0] prev_q;
    logic [N-1:0] rise_q;
    logic [N-1:0] rise_d;

    always_comb begin
        rise_d = sync_q & ~prev_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= '0;
            sync_q <= '0;
            prev_q <= '0;
            rise_q <= '0;
        end else begin
            meta_q <= sw_i;
            sync_q <= meta_q;
            prev_q <= sync_q;
            rise_q <= rise_d;
        end
    end

    assign rise_o = rise_q;

endmodule

// File: rtl/matrix_paint_engine.sv
// ----------------------------------------------------------------------------
// matrix_paint_engine
//   Two-player paint engine for a WIDTH x HEIGHT LED matrix. Each player owns a
//   cursor that moves with wrap-around; players toggle the pixel under their
//   cursor or clear the whole framebuffer, all on switch rising edges.
//   Pixel index on the flat bus is y*WIDTH + x.
//   Optional feature macro: CURSOR_BLINK_EN -- when defined, cursor pixels are
//   inverted on the output during alternate BLINK_DIV-cycle phases.
// Ports
//   clk          in   1             system clock
//   rst_n        in   1             asynchronous reset, active low
//   switches_p1  in   SW_W          player 1 switches (async)
//   switches_p2  in   SW_W          player 2 switches (async)
//   matrix       out  WIDTH*HEIGHT  LED drive, 1 = lit (from registered state only)
// ----------------------------------------------------------------------------
module matrix_paint_engine
    import matrix_pkg::*;
#(
    parameter int unsigned WIDTH     = 4,
    parameter int unsigned HEIGHT    = 4,
    parameter int unsigned SW_W      = 8,
    parameter int unsigned BLINK_DIV = 6000000
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [SW_W-1:0]         switches_p1,
    input  logic [SW_W-1:0]         switches_p2,
    output logic [WIDTH*HEIGHT-1:0] matrix
);

    localparam int unsigned NPIX = WIDTH * HEIGHT;

    logic [SW_USED-1:0] rise_p1;
    logic [SW_USED-1:0] rise_p2;

    cursor_t         p1_q, p1_d;
    cursor_t         p2_q, p2_d;
    logic [NPIX-1:0] fb_q, fb_d;

    switch_edge_sync #(
        .N (SW_USED)
    ) u_sync_p1 (
        .clk    (clk),
        .rst_n  (rst_n),
        .sw_i   (switches_p1[SW_USED-1:0]),
        .rise_o (rise_p1)
    );

    switch_edge_sync #(
        .N (SW_USED)
    ) u_sync_p2 (
        .clk    (clk),
        .rst_n  (rst_n),
        .sw_i   (switches_p2[SW_USED-1:0]),
        .rise_o (rise_p2)
    );

    generate
        if (SW_W > SW_USED) begin : g_unused_sw
            logic unused_sw;
            assign unused_sw = ^{switches_p1[SW_W-1:SW_USED], switches_p2[SW_W-1:SW_USED]};
        end
    endgenerate

    // One-hot mask of the pixel under a cursor.
    function automatic logic [NPIX-1:0] pix_mask(cursor_t c);
        logic [NPIX-1:0] m;
        int unsigned     idx;
        m   = '0;
        idx = int'(c.y) * WIDTH + int'(c.x);
        for (int unsigned i = 0; i < NPIX; i++) begin
            if (i == idx) begin
                m[i] = 1'b1;
            end
        end
        return m;
    endfunction

    function automatic cursor_t move(cursor_t c, logic [SW_USED-1:0] r);
        cursor_t n;
        n.x = wrap_step(c.x, r[SW_RIGHT], r[SW_LEFT], WIDTH);
        n.y = wrap_step(c.y, r[SW_DOWN], r[SW_UP], HEIGHT);
        return n;
    endfunction

    always_comb begin
        logic [NPIX-1:0] tog;
        tog = '0;
        // Toggles use the cursor positions held before this cycle's moves.
        if (rise_p1[SW_TOGGLE]) begin
            tog = tog | pix_mask(p1_q);
        end
        if (rise_p2[SW_TOGGLE]) begin
            tog = tog | pix_mask(p2_q);
        end
        // OR-ing the masks makes a shared pixel invert once.
        fb_d = fb_q ^ tog;
        if (rise_p1[SW_CLEAR] || rise_p2[SW_CLEAR]) begin
            fb_d = '0;
        end
        p1_d = move(p1_q, rise_p1);
        p2_d = move(p2_q, rise_p2);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fb_q   <= '0;
            p1_q.x <= '0;
            p1_q.y <= '0;
            p2_q.x <= coord_t'(WIDTH - 1);
            p2_q.y <= coord_t'(HEIGHT - 1);
        end else begin
            fb_q <= fb_d;
            p1_q <= p1_d;
            p2_q <= p2_d;
        end
    end

`ifdef CURSOR_BLINK_EN
    localparam int unsigned CNT_W = $clog2(BLINK_DIV);

    logic [CNT_W-1:0] blink_cnt_q;
    logic             blink_phase_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blink_cnt_q   <= '0;
            blink_phase_q <= 1'b0;
        end else if (blink_cnt_q == CNT_W'(BLINK_DIV - 1)) begin
            blink_cnt_q   <= '0;
            blink_phase_q <= ~blink_phase_q;
        end else begin
            blink_cnt_q <= blink_cnt_q + CNT_W'(1);
        end
    end

    // Overlapping cursors produce a single inversion because the masks are OR-ed.
    assign matrix = blink_phase_q ? (fb_q ^ (pix_mask(p1_q) | pix_mask(p2_q))) : fb_q;
`else
    logic unused_blink;
    assign unused_blink = (BLINK_DIV == 0);
    assign matrix = fb_q;
`endif

endmodule
